// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point add/subtract unit.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  localparam int STATUS_W     = 4;
  localparam int ST_EXACT     = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_INEXACT   = 3;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fp_lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] cnt
);

  // Scan upward so the highest set bit has the final say.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++)
      if (d[i]) cnt = CW'(W - 1 - i);
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Multi-cycle floating-point add/subtract: IDLE/ALIGN/ADD/NORM/ROUND/DONE.
// Build option: define FPADD_ROUND_EN for round-to-nearest-even; otherwise
// the ROUND state truncates (latency unchanged, inexact still reported).
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 6,
  parameter int MAN_W = 25
) (
  input  logic                      clock_100kHz,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+MAN_W:0]      op_A_in,
  input  logic [EXP_W+MAN_W:0]      op_B_in,
  input  logic                      op_sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+MAN_W:0]      data_out,
  output logic [STATUS_W-1:0]       status_out
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 1;   // hidden + stored mantissa
  localparam int SH_W  = MAN_W + 3;   // hidden, mantissa, guard, round
  localparam int X_W   = MAN_W + 4;   // ... plus sticky at bit 0
  localparam int E_W   = EXP_W + 2;
  localparam int LZ_W  = $clog2(MAN_W + 3);
  localparam logic signed [E_W-1:0] EMAX = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] EONE = E_W'(1);

  state_t state, state_nx;

  logic                    sgn_r, eff_sub_r, zero_r;
  logic [EXP_W-1:0]        ea_r, eb_r;
  logic [SIG_W-1:0]        ma_r, mb_r;
  logic [X_W-1:0]          xb_r, nm_r;
  logic [X_W:0]            sum_r;
  logic signed [E_W-1:0]   e_r;

  // Operand unpacking and magnitude compare at accept time
  logic [EXP_W-1:0] ea_in, eb_in;
  logic [SIG_W-1:0] ma_in, mb_in;
  logic             sa_in, sb_in, swap;

  always_comb begin
    ea_in = op_A_in[W-2:MAN_W];
    eb_in = op_B_in[W-2:MAN_W];
    ma_in = (ea_in == '0) ? '0 : {1'b1, op_A_in[MAN_W-1:0]};
    mb_in = (eb_in == '0) ? '0 : {1'b1, op_B_in[MAN_W-1:0]};
    sa_in = op_A_in[W-1];
    sb_in = op_B_in[W-1] ^ op_sub;
    swap  = {eb_in, mb_in} > {ea_in, ma_in};
  end

  // Alignment: right shift B with sticky collection
  logic [EXP_W-1:0]    dexp;
  logic [2*SH_W-1:0]   sh_wide;
  logic [X_W-1:0]      xb_nx;

  always_comb begin
    dexp    = ea_r - eb_r;
    sh_wide = {mb_r, 2'b00, {SH_W{1'b0}}} >> dexp;
    if (int'(dexp) >= SH_W) xb_nx = {{SH_W{1'b0}}, |mb_r};
    else                    xb_nx = {sh_wide[2*SH_W-1:SH_W], |sh_wide[SH_W-1:0]};
  end

  // Magnitude add or subtract (A is never smaller than B)
  logic [X_W:0] sum_nx;

  always_comb begin
    if (eff_sub_r) sum_nx = {1'b0, ma_r, 3'b000} - {1'b0, xb_r};
    else           sum_nx = {1'b0, ma_r, 3'b000} + {1'b0, xb_r};
  end

  // Normalisation: carry shifts right, otherwise shift out leading zeros
  logic [LZ_W-1:0]        lz;
  logic [X_W-1:0]         nm_nx;
  logic signed [E_W-1:0]  ne_nx;

  fp_lzc #(.W(MAN_W + 2), .CW(LZ_W)) u_lzc (
    .d   (sum_r[X_W-1:2]),
    .cnt (lz)
  );

  always_comb begin
    if (sum_r[X_W]) begin
      nm_nx = {sum_r[X_W:2], sum_r[1] | sum_r[0]};
      ne_nx = e_r + EONE;
    end else begin
      nm_nx = sum_r[X_W-1:0] << lz;
      ne_nx = e_r - E_W'(lz);
    end
  end

  // Rounding and exception classification
  logic                   rnd;
  logic [MAN_W+1:0]       mr;
  logic [MAN_W-1:0]       man_f;
  logic signed [E_W-1:0]  ef;
  logic [W-1:0]           res_nx;
  logic [STATUS_W-1:0]    st_nx;

  always_comb begin
`ifdef FPADD_ROUND_EN
    rnd = nm_r[2] & (nm_r[1] | nm_r[0] | nm_r[3]);
`else
    rnd = 1'b0;
`endif
    mr = {1'b0, nm_r[X_W-1:3]} + (MAN_W+2)'(rnd);
    if (mr[MAN_W+1]) begin
      man_f = mr[MAN_W:1];
      ef    = e_r + EONE;
    end else begin
      man_f = mr[MAN_W-1:0];
      ef    = e_r;
    end
    st_nx = '0;
    if (zero_r) begin
      res_nx          = '0;
      st_nx[ST_EXACT] = 1'b1;
    end else if (ef >= EMAX) begin
      res_nx             = {sgn_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      st_nx[ST_OVERFLOW] = 1'b1;
    end else if (ef < EONE) begin
      res_nx              = {sgn_r, {(W-1){1'b0}}};
      st_nx[ST_UNDERFLOW] = 1'b1;
    end else begin
      res_nx = {sgn_r, ef[EXP_W-1:0], man_f};
      if (|nm_r[2:0]) st_nx[ST_INEXACT] = 1'b1;
      else            st_nx[ST_EXACT]   = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clock_100kHz) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: fixed walk through the stages, DONE waits for out_ready
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_ALIGN;
      S_ALIGN: state_nx = S_ADD;
      S_ADD:   state_nx = S_NORM;
      S_NORM:  state_nx = S_ROUND;
      S_ROUND: state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Datapath stage registers, loaded in the state that produces them
  always_ff @(posedge clock_100kHz) begin
    case (state)
      S_IDLE: if (in_valid) begin
        eff_sub_r <= sa_in ^ sb_in;
        if (swap) begin
          sgn_r <= sb_in; ea_r <= eb_in; ma_r <= mb_in; eb_r <= ea_in; mb_r <= ma_in;
        end else begin
          sgn_r <= sa_in; ea_r <= ea_in; ma_r <= ma_in; eb_r <= eb_in; mb_r <= mb_in;
        end
      end
      S_ALIGN: xb_r <= xb_nx;
      S_ADD: begin
        sum_r <= sum_nx;
        e_r   <= $signed({2'b00, ea_r});
      end
      S_NORM: begin
        nm_r   <= nm_nx;
        e_r    <= ne_nx;
        zero_r <= (sum_r == '0);
      end
      default: ;
    endcase
  end

  // Result registers: captured leaving ROUND, held through DONE
  always_ff @(posedge clock_100kHz) begin
    if (reset) begin
      data_out   <= '0;
      status_out <= STATUS_W'(1 << ST_EXACT);
    end else if (state == S_ROUND) begin
      data_out   <= res_nx;
      status_out <= st_nx;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe at EXP_W=6, MAN_W=25.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] op_A_in, op_B_in, data_out;
  logic [3:0]  status_out;

  int n_chk  = 0;
  int n_pass = 0;
  logic [35:0] sb_q[$];
  int  lat;
  bit  tracking = 1'b0;

  always #5 clk = ~clk;

  fp_addsub_pipe #(.EXP_W(6), .MAN_W(25)) dut (
    .clock_100kHz (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_A_in      (op_A_in),
    .op_B_in      (op_B_in),
    .op_sub       (op_sub),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_out     (data_out),
    .status_out   (status_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, want);
  endtask

  // Drive one operation when the unit is ready; queue its expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [31:0] ed, input logic [3:0] es);
    int t = 0;
    while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) chk("in_ready_timeout", 32'(t), 32'd0);
    op_A_in = a; op_B_in = b; op_sub = sub; in_valid = 1'b1;
    sb_q.push_back({es, ed});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Output monitor: latency from accept cycle and scoreboard compare
  always @(negedge clk) begin
    logic [35:0] e;
    if (reset) tracking = 1'b0;
    else begin
      if (tracking) lat++;
      if (out_valid) begin
        if (tracking) begin chk("latency", 32'(lat), 32'd5); tracking = 1'b0; end
        if (out_ready) begin
          if (sb_q.size() == 0) chk("spurious_out", 32'(sb_q.size()), 32'd1);
          else begin
            e = sb_q.pop_front();
            chk("data", data_out, e[31:0]);
            chk("status", {28'd0, status_out}, {28'd0, e[35:32]});
          end
        end
      end
      if (in_valid && in_ready) begin tracking = 1'b1; lat = 0; end
    end
  end

  initial begin
    logic [31:0] held_d;
    logic [3:0]  held_s;
    int t;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_sub = 1'b0;
    op_A_in = '0; op_B_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_status", {28'd0, status_out}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    send(32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'b0001); // 1+1
    send(32'h3E000000, 32'h3E000000, 1'b1, 32'h00000000, 4'b0001); // 1-1
    send(32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 32'h7E000000, 4'b0010); // overflow
    send(32'h02000000, 32'h02000001, 1'b1, 32'h80000000, 4'b0100); // underflow
    send(32'h3E000000, 32'h3C000000, 1'b0, 32'h3F000000, 4'b0001); // 1+0.5
    send(32'h3E000000, 32'h3C000000, 1'b1, 32'h3C000000, 4'b0001); // 1-0.5
    send(32'h3C000000, 32'h3E000000, 1'b1, 32'hBC000000, 4'b0001); // 0.5-1, swap
    send(32'hBE000000, 32'h3C000000, 1'b0, 32'hBC000000, 4'b0001); // -1+0.5
    send(32'h00000005, 32'h3E000000, 1'b0, 32'h3E000000, 4'b0001); // zero operand
    send(32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b1000); // tie, even lsb
    send(32'h3E000000, 32'h02000000, 1'b0, 32'h3E000000, 4'b1000); // shift >= 28
`ifdef FPADD_ROUND_EN
    send(32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000002, 4'b1000); // tie, odd lsb
    send(32'h3E000000, 32'h0A000001, 1'b0, 32'h3E000001, 4'b1000); // above half
    send(32'h3FFFFFFF, 32'h0A000001, 1'b0, 32'h40000000, 4'b1000); // round carry
`else
    send(32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000001, 4'b1000);
    send(32'h3E000000, 32'h0A000001, 1'b0, 32'h3E000000, 4'b1000);
    send(32'h3FFFFFFF, 32'h0A000001, 1'b0, 32'h3FFFFFFF, 4'b1000);
`endif

    // Back-pressure: hold DONE for 10 cycles
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h3E000000, 32'h3C000000, 1'b0, 32'h3F000000, 4'b0001);
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    chk("bp_reached_done", {31'd0, out_valid}, 32'd1);
    held_d = data_out; held_s = status_out;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_data", data_out, held_d);
      chk("bp_status", {28'd0, status_out}, {28'd0, held_s});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Reset during ALIGN aborts the operation
    t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    op_A_in = 32'h3E000000; op_B_in = 32'h3E000000; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_align", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_data", data_out, 32'd0);
    chk("abort_status", {28'd0, status_out}, 32'd1);
    repeat (8) @(posedge clk);

    t = 0;
    while (sb_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk("drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
